// File: rtl/baud_pkg.sv
// Shared constants and types for the fractional baud-rate generator.
package baud_pkg;

    localparam int unsigned MIN_DIV = 2;

    // 100 MHz / (baud * 16): integer part plus fraction in 1/16ths
    localparam int unsigned DIV_9600_INT    = 651;
    localparam int unsigned DIV_9600_FRAC   = 1;
    localparam int unsigned DIV_115200_INT  = 54;
    localparam int unsigned DIV_115200_FRAC = 4;

    typedef enum logic [0:0] {
        StIdle,
        StPending
    } load_state_t;

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional phase accumulator: adds act_frac once per sample period and
// reports the carry that stretches the current period by one cycle.
`ifdef BAUD_FRAC_EN
module baud_frac_acc #(
    parameter int unsigned FRAC_W = 4
) (
    input  logic              clk_100MHz,
    input  logic              reset_n,
    input  logic [FRAC_W-1:0] act_frac,
    input  logic              advance,
    input  logic              clear,
    output logic              carry
);

    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [FRAC_W:0]   sum;

    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, act_frac};
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (advance) begin
            acc_d = sum[FRAC_W-1:0];
        end
    end

    assign carry = sum[FRAC_W];

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule
`endif

// File: rtl/baud_gen_frac.sv
// Runtime-programmable baud-rate generator producing sample and bit ticks.
// Define BAUD_FRAC_EN to include the fractional divisor accumulator.
module baud_gen_frac
    import baud_pkg::*;
#(
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned FRAC_W   = 4,
    parameter int unsigned OSR      = 16,
    parameter int unsigned DEF_INT  = DIV_9600_INT,
    parameter int unsigned DEF_FRAC = DIV_9600_FRAC
) (
    input  logic              clk_100MHz,
    input  logic              reset_n,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    input  logic              resync,
    output logic              sample_tick,
    output logic              bit_tick,
    output logic              div_pending
);

    localparam int unsigned OSR_W = $clog2(OSR);

    load_state_t      state_q, state_d;
    logic [DIV_W-1:0] act_int_q, act_int_d;
    logic [DIV_W-1:0] sh_int_q, sh_int_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [OSR_W-1:0] osr_q, osr_d;

    logic [DIV_W-1:0] eff;
    logic [DIV_W:0]   limit;
    logic [DIV_W:0]   limit_m1;
    logic             carry;
    logic             apply_tick;
    logic             acc_clear;

    assign eff      = (act_int_q < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : act_int_q;
    assign limit    = {1'b0, eff} + {{DIV_W{1'b0}}, carry};
    assign limit_m1 = limit - {{DIV_W{1'b0}}, 1'b1};

    // resync owns the cycle, so it masks any tick that would otherwise land on it
    assign sample_tick = en && !resync && ({1'b0, cnt_q} == limit_m1);
    assign bit_tick    = sample_tick && (osr_q == OSR_W'(OSR - 1));
    assign div_pending = (state_q == StPending);

    assign apply_tick = (state_q == StPending) && sample_tick;
    assign acc_clear  = resync || apply_tick;

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;

    baud_frac_acc #(
        .FRAC_W (FRAC_W)
    ) u_frac_acc (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .act_frac   (act_frac_q),
        .advance    (sample_tick),
        .clear      (acc_clear),
        .carry      (carry)
    );

    always_comb begin
        act_frac_d = act_frac_q;
        sh_frac_d  = sh_frac_q;
        if (resync) begin
            if (div_load) begin
                act_frac_d = div_frac;
            end else if (state_q == StPending) begin
                act_frac_d = sh_frac_q;
            end
        end else begin
            if (apply_tick) begin
                act_frac_d = sh_frac_q;
            end
            if (div_load) begin
                sh_frac_d = div_frac;
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            act_frac_q <= FRAC_W'(DEF_FRAC);
            sh_frac_q  <= '0;
        end else begin
            act_frac_q <= act_frac_d;
            sh_frac_q  <= sh_frac_d;
        end
    end
`else
    logic unused_frac;

    assign carry       = 1'b0;
    assign unused_frac = ^{div_frac, FRAC_W'(DEF_FRAC), acc_clear};
`endif

    // Load control: a captured divisor waits for the next tick unless resync forces it in
    always_comb begin
        state_d   = state_q;
        act_int_d = act_int_q;
        sh_int_d  = sh_int_q;
        if (resync) begin
            if (div_load) begin
                act_int_d = div_int;
                state_d   = StIdle;
            end else if (state_q == StPending) begin
                act_int_d = sh_int_q;
                state_d   = StIdle;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (div_load) begin
                        sh_int_d = div_int;
                        state_d  = StPending;
                    end
                end
                StPending: begin
                    if (sample_tick) begin
                        act_int_d = sh_int_q;
                        state_d   = StIdle;
                    end
                    if (div_load) begin
                        sh_int_d = div_int;
                        state_d  = StPending;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        osr_d = osr_q;
        if (resync) begin
            cnt_d = '0;
            osr_d = '0;
        end else if (sample_tick) begin
            cnt_d = '0;
            osr_d = (osr_q == OSR_W'(OSR - 1)) ? '0 : osr_q + OSR_W'(1);
        end else if (en) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            act_int_q <= DIV_W'(DEF_INT);
            sh_int_q  <= '0;
            cnt_q     <= '0;
            osr_q     <= '0;
        end else begin
            state_q   <= state_d;
            act_int_q <= act_int_d;
            sh_int_q  <= sh_int_d;
            cnt_q     <= cnt_d;
            osr_q     <= osr_d;
        end
    end

endmodule
